// File: rtl/udp_oe_csr_init_host.sv
// Avalon-MM host that programs the nine UDP OE CSRs from a captured configuration,
// then reads every register back and reports done or error (mismatch / read timeout).
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start; cfg_* captured on the accepting cycle
// S_WR      | write register idx, held while waitrequest
// S_RD_REQ  | read command for register idx, held while waitrequest
// S_RD_WAIT | one read outstanding, timeout timer running
// S_CHECK   | compare captured readdata with shadow value of idx
// S_DONE    | one-cycle done pulse
// S_ERR     | error latched, back to idle
module udp_oe_csr_init_host #(
    parameter int unsigned ADDR_W         = 13,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [9:0]  REG_ADDR_0     = 10'h000,
    parameter logic [9:0]  REG_ADDR_1     = 10'h001,
    parameter logic [9:0]  REG_ADDR_2     = 10'h002,
    parameter logic [9:0]  REG_ADDR_3     = 10'h003,
    parameter logic [9:0]  REG_ADDR_4     = 10'h004,
    parameter logic [9:0]  REG_ADDR_5     = 10'h005,
    parameter logic [9:0]  REG_ADDR_6     = 10'h006,
    parameter logic [9:0]  REG_ADDR_7     = 10'h007,
    parameter logic [9:0]  REG_ADDR_8     = 10'h008
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [47:0]       cfg_fpga_mac,
    input  logic [31:0]       cfg_fpga_ip,
    input  logic [15:0]       cfg_fpga_udp_port,
    input  logic [31:0]       cfg_fpga_netmask,
    input  logic [47:0]       cfg_host_mac,
    input  logic [31:0]       cfg_host_ip,
    input  logic [15:0]       cfg_host_udp_port,
    input  logic [15:0]       cfg_payload_per_packet,
    input  logic [15:0]       cfg_checksum_ip,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic [7:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [3:0]        err_index,
    output logic [1:0]        err_code
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD_REQ, S_RD_WAIT, S_CHECK, S_DONE, S_ERR
    } state_t;

    typedef struct packed {
        logic [47:0] fpga_mac;
        logic [31:0] fpga_ip;
        logic [15:0] fpga_udp_port;
        logic [31:0] fpga_netmask;
        logic [47:0] host_mac;
        logic [31:0] host_ip;
        logic [15:0] host_udp_port;
        logic [15:0] payload_per_packet;
        logic [15:0] checksum_ip;
    } cfg_t;

    state_t            state_q, state_d;
    cfg_t              cfg_q, cfg_d;
    logic [3:0]        idx_q, idx_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    logic [3:0]        err_index_q, err_index_d;
    logic [1:0]        err_code_q, err_code_d;

    logic [9:0]        cur_word;
    logic [63:0]       cur_val;

    // Register map lookup for the current index; values are zero-extended to 64 bits.
    always_comb begin
        cur_word = 10'h000;
        cur_val  = 64'h0;
        case (idx_q)
            4'd0: begin cur_word = REG_ADDR_0; cur_val = {16'h0, cfg_q.fpga_mac};           end
            4'd1: begin cur_word = REG_ADDR_1; cur_val = {32'h0, cfg_q.fpga_ip};            end
            4'd2: begin cur_word = REG_ADDR_2; cur_val = {48'h0, cfg_q.fpga_udp_port};      end
            4'd3: begin cur_word = REG_ADDR_3; cur_val = {32'h0, cfg_q.fpga_netmask};       end
            4'd4: begin cur_word = REG_ADDR_4; cur_val = {16'h0, cfg_q.host_mac};           end
            4'd5: begin cur_word = REG_ADDR_5; cur_val = {32'h0, cfg_q.host_ip};            end
            4'd6: begin cur_word = REG_ADDR_6; cur_val = {48'h0, cfg_q.host_udp_port};      end
            4'd7: begin cur_word = REG_ADDR_7; cur_val = {48'h0, cfg_q.payload_per_packet}; end
            4'd8: begin cur_word = REG_ADDR_8; cur_val = {48'h0, cfg_q.checksum_ip};        end
            default: begin cur_word = 10'h000; cur_val = 64'h0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cfg_q       <= '0;
            idx_q       <= '0;
            tmr_q       <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            idx_q       <= idx_d;
            tmr_q       <= tmr_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
            err_code_q  <= err_code_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        idx_d       = idx_q;
        tmr_d       = tmr_q;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        error_d     = error_q;
        err_index_d = err_index_q;
        err_code_d  = err_code_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_d       = '{cfg_fpga_mac, cfg_fpga_ip, cfg_fpga_udp_port,
                                    cfg_fpga_netmask, cfg_host_mac, cfg_host_ip,
                                    cfg_host_udp_port, cfg_payload_per_packet,
                                    cfg_checksum_ip};
                    idx_d       = 4'd0;
                    error_d     = 1'b0;
                    err_index_d = 4'd0;
                    err_code_d  = 2'd0;
                    busy_d      = 1'b1;
                    state_d     = S_WR;
                end
            end
            S_WR: begin
                if (!avm_waitrequest) begin
                    if (idx_q == 4'd8) begin
                        idx_d   = 4'd0;
                        state_d = S_RD_REQ;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_RD_REQ: begin
                if (!avm_waitrequest) begin
                    tmr_d   = TMR_W'(TIMEOUT_CYCLES);
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                // Data arriving on the last permitted cycle still wins over the timeout.
                if (avm_readdatavalid) begin
                    rdata_d = avm_readdata;
                    state_d = S_CHECK;
                end else if (tmr_q <= TMR_W'(1)) begin
                    error_d     = 1'b1;
                    err_code_d  = 2'd2;
                    err_index_d = idx_q;
                    busy_d      = 1'b0;
                    state_d     = S_ERR;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_CHECK: begin
                if (rdata_q != DATA_W'(cur_val)) begin
                    error_d     = 1'b1;
                    err_code_d  = 2'd1;
                    err_index_d = idx_q;
                    busy_d      = 1'b0;
                    state_d     = S_ERR;
                end else if (idx_q == 4'd8) begin
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_RD_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        avm_write      = 1'b0;
        avm_read       = 1'b0;
        avm_address    = '0;
        avm_writedata  = '0;
        avm_byteenable = 8'hFF;
        done           = 1'b0;
        case (state_q)
            S_WR: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_W'({cur_word, 3'b000});
                avm_writedata = DATA_W'(cur_val);
            end
            S_RD_REQ: begin
                avm_read    = 1'b1;
                avm_address = ADDR_W'({cur_word, 3'b000});
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign busy      = busy_q;
    assign error     = error_q;
    assign err_index = err_index_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_udp_oe_csr_init_host.sv
// Bench for udp_oe_csr_init_host: an Avalon agent with scripted stalls, delays and
// corrupt data, plus a transaction-level model of the nine-register write/readback.
module tb_udp_oe_csr_init_host;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [47:0] cfg_fpga_mac = '0;
    logic [31:0] cfg_fpga_ip = '0;
    logic [15:0] cfg_fpga_udp_port = '0;
    logic [31:0] cfg_fpga_netmask = '0;
    logic [47:0] cfg_host_mac = '0;
    logic [31:0] cfg_host_ip = '0;
    logic [15:0] cfg_host_udp_port = '0;
    logic [15:0] cfg_payload_per_packet = '0;
    logic [15:0] cfg_checksum_ip = '0;
    logic [12:0] avm_address;
    logic        avm_read, avm_write;
    logic [63:0] avm_writedata;
    logic [7:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;
    logic [63:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        busy, done, error;
    logic [3:0]  err_index;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    udp_oe_csr_init_host #(
        .ADDR_W(13), .DATA_W(64), .TIMEOUT_CYCLES(255),
        .REG_ADDR_0(10'h100), .REG_ADDR_1(10'h102), .REG_ADDR_2(10'h104),
        .REG_ADDR_3(10'h106), .REG_ADDR_4(10'h108), .REG_ADDR_5(10'h10A),
        .REG_ADDR_6(10'h10C), .REG_ADDR_7(10'h10E), .REG_ADDR_8(10'h110)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_fpga_mac(cfg_fpga_mac), .cfg_fpga_ip(cfg_fpga_ip),
        .cfg_fpga_udp_port(cfg_fpga_udp_port), .cfg_fpga_netmask(cfg_fpga_netmask),
        .cfg_host_mac(cfg_host_mac), .cfg_host_ip(cfg_host_ip),
        .cfg_host_udp_port(cfg_host_udp_port), .cfg_payload_per_packet(cfg_payload_per_packet),
        .cfg_checksum_ip(cfg_checksum_ip),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy(busy), .done(done), .error(error), .err_index(err_index), .err_code(err_code)
    );

    int checks = 0;
    int errors = 0;
    int tk;
    int wr_cnt, rd_cnt;
    int stall_wr_idx = -1, stall_rd_idx = -1, wr_stall_left = 0, rd_stall_left = 0;
    int bad_idx = -1, dly_idx = -1, dly_val = 1;
    int rsp_timer = 0;
    logic [63:0] rsp_data;
    logic [63:0] exp_val [9];
    logic [12:0] exp_addr [9];
    logic [12:0] wr_log_addr [9];
    logic [63:0] wr_log_data [9];
    bit          seq_active = 1'b0;
    bit          prev_stall = 1'b0;
    logic        prev_rd, prev_wr;
    logic [12:0] prev_addr;
    logic [63:0] prev_data;
    int          done_tk, err_tk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: register i lives at byte address (0x100 + 2*i) * 8, value zero-extended.
    task automatic build_model();
        for (int i = 0; i < 9; i++) exp_addr[i] = 13'((10'h100 + 2 * i) * 8);
        exp_val[0] = {16'h0, cfg_fpga_mac};
        exp_val[1] = {32'h0, cfg_fpga_ip};
        exp_val[2] = {48'h0, cfg_fpga_udp_port};
        exp_val[3] = {32'h0, cfg_fpga_netmask};
        exp_val[4] = {16'h0, cfg_host_mac};
        exp_val[5] = {32'h0, cfg_host_ip};
        exp_val[6] = {48'h0, cfg_host_udp_port};
        exp_val[7] = {48'h0, cfg_payload_per_packet};
        exp_val[8] = {48'h0, cfg_checksum_ip};
    endtask

    // One clock: sample outputs 1 ns after the edge, check them, then drive the agent.
    task automatic tick();
        @(posedge clk);
        #1;
        tk++;
        chk("rd_wr_exclusive", 64'(avm_read && avm_write), 64'd0);
        chk("byteenable", 64'(avm_byteenable), 64'hFF);
        chk("cmd_outside_seq", 64'((avm_read || avm_write) && !seq_active), 64'd0);
        if (prev_stall) begin
            chk("stall_cmd_hold", 64'({avm_read, avm_write}), 64'({prev_rd, prev_wr}));
            chk("stall_addr_hold", 64'(avm_address), 64'(prev_addr));
            chk("stall_data_hold", avm_writedata, prev_data);
        end
        if (done && seq_active) begin
            chk("done_busy_low", 64'(busy), 64'd0);
            done_tk = tk;
            seq_active = 1'b0;
        end
        if (error && seq_active) begin
            chk("err_busy_low", 64'(busy), 64'd0);
            err_tk = tk;
            seq_active = 1'b0;
        end
        avm_readdatavalid = 1'b0;
        if (rsp_timer > 0) begin
            rsp_timer--;
            if (rsp_timer == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = rsp_data;
            end
        end
        prev_stall = 1'b0;
        avm_waitrequest = 1'b0;
        if (avm_write) begin
            if (wr_cnt == stall_wr_idx && wr_stall_left > 0) begin
                wr_stall_left--;
                avm_waitrequest = 1'b1;
            end else if (wr_cnt > 8) begin
                chk("wr_count", 64'(wr_cnt), 64'd8);
            end else begin
                chk("wr_addr", 64'(avm_address), 64'(exp_addr[wr_cnt]));
                chk("wr_data", avm_writedata, exp_val[wr_cnt]);
                wr_log_addr[wr_cnt] = avm_address;
                wr_log_data[wr_cnt] = avm_writedata;
                wr_cnt++;
            end
        end
        if (avm_read) begin
            if (rd_cnt == stall_rd_idx && rd_stall_left > 0) begin
                rd_stall_left--;
                avm_waitrequest = 1'b1;
            end else if (rd_cnt > 8) begin
                chk("rd_count", 64'(rd_cnt), 64'd8);
            end else begin
                chk("rd_after_writes", 64'(wr_cnt), 64'd9);
                chk("rd_addr", 64'(avm_address), 64'(exp_addr[rd_cnt]));
                chk("rd_single_outstanding", 64'(rsp_timer), 64'd0);
                rsp_data = exp_val[rd_cnt];
                if (rd_cnt == bad_idx) rsp_data[50] = 1'b1;
                rsp_timer = (rd_cnt == dly_idx) ? dly_val : 1;
                rd_cnt++;
            end
        end
        if (avm_waitrequest) begin
            prev_stall = 1'b1;
            prev_rd = avm_read;
            prev_wr = avm_write;
            prev_addr = avm_address;
            prev_data = avm_writedata;
        end
    endtask

    task automatic begin_seq();
        build_model();
        wr_cnt = 0;
        rd_cnt = 0;
        done_tk = -1;
        err_tk = -1;
        tk = 0;
        start = 1'b1;
        seq_active = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("error_cleared", 64'(error), 64'd0);
        chk("err_code_cleared", 64'(err_code), 64'd0);
        chk("first_cmd_write", 64'(avm_write), 64'd1);
    endtask

    task automatic invert_cfg();
        cfg_fpga_mac = ~cfg_fpga_mac;         cfg_fpga_ip = ~cfg_fpga_ip;
        cfg_fpga_udp_port = ~cfg_fpga_udp_port; cfg_fpga_netmask = ~cfg_fpga_netmask;
        cfg_host_mac = ~cfg_host_mac;         cfg_host_ip = ~cfg_host_ip;
        cfg_host_udp_port = ~cfg_host_udp_port;
        cfg_payload_per_packet = ~cfg_payload_per_packet;
        cfg_checksum_ip = ~cfg_checksum_ip;
    endtask

    task automatic run_seq(input int restart_tk, input int max_tk);
        begin_seq();
        while (seq_active && tk < max_tk) begin
            if (tk == restart_tk) begin
                start = 1'b1;
                invert_cfg();
            end
            tick();
            start = 1'b0;
        end
        if (seq_active) begin
            chk("seq_cycle_bound", 64'(tk), 64'(max_tk - 1));
            seq_active = 1'b0;
        end
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_done", 64'(done), 64'd0);
        end
    endtask

    initial begin
        tk = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read", 64'(avm_read), 64'd0);
        chk("rst_write", 64'(avm_write), 64'd0);
        chk("rst_addr", 64'(avm_address), 64'd0);
        chk("rst_byteen", 64'(avm_byteenable), 64'hFF);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_err_index", 64'(err_index), 64'd0);
        chk("rst_err_code", 64'(err_code), 64'd0);
        reset = 1'b0;
        idle_ticks(2);

        // Zero-wait agent, distinct values
        cfg_fpga_mac = 48'h0102_0304_0506;  cfg_fpga_ip = 32'hC0A8_0001;
        cfg_fpga_udp_port = 16'd5000;       cfg_fpga_netmask = 32'hFFFF_FF00;
        cfg_host_mac = 48'hA1B2_C3D4_E5F6;  cfg_host_ip = 32'hC0A8_0002;
        cfg_host_udp_port = 16'd6000;       cfg_payload_per_packet = 16'd1024;
        cfg_checksum_ip = 16'hBEEF;
        run_seq(-1, 400);
        chk("t1_done_tick", 64'(done_tk), 64'd37);
        chk("t1_writes", 64'(wr_cnt), 64'd9);
        chk("t1_reads", 64'(rd_cnt), 64'd9);
        chk("t1_error", 64'(error), 64'd0);
        chk("lit_wr0_data", wr_log_data[0], 64'h0000_0102_0304_0506);
        chk("lit_wr0_addr", 64'(wr_log_addr[0]), 64'h800);
        chk("lit_wr7_data", wr_log_data[7], 64'd1024);
        chk("lit_wr7_addr", 64'(wr_log_addr[7]), 64'h870);
        chk("lit_wr4_data", wr_log_data[4], 64'h0000_A1B2_C3D4_E5F6);
        idle_ticks(2);

        // Stalls on write idx 2 and read idx 5
        stall_wr_idx = 2; wr_stall_left = 3;
        stall_rd_idx = 5; rd_stall_left = 3;
        run_seq(-1, 400);
        chk("t2_done_tick", 64'(done_tk), 64'd43);
        chk("t2_writes", 64'(wr_cnt), 64'd9);
        chk("t2_reads", 64'(rd_cnt), 64'd9);
        stall_wr_idx = -1; stall_rd_idx = -1;
        idle_ticks(2);

        // Bit 50 set in host MAC readback
        bad_idx = 4;
        run_seq(-1, 400);
        chk("t3_err_tick", 64'(err_tk), 64'd25);
        chk("t3_error", 64'(error), 64'd1);
        chk("t3_err_code", 64'(err_code), 64'd1);
        chk("t3_err_index", 64'(err_index), 64'd4);
        bad_idx = -1;
        idle_ticks(5);
        chk("t3_reads", 64'(rd_cnt), 64'd5);
        chk("t3_error_sticky", 64'(error), 64'd1);

        // No readdatavalid for idx 0 -> timeout
        dly_idx = 0; dly_val = 0;
        run_seq(-1, 600);
        chk("t4_err_tick", 64'(err_tk), 64'd266);
        chk("t4_error", 64'(error), 64'd1);
        chk("t4_err_code", 64'(err_code), 64'd2);
        chk("t4_err_index", 64'(err_index), 64'd0);
        idle_ticks(3);

        // readdatavalid on the last permitted cycle
        dly_idx = 0; dly_val = 255;
        run_seq(-1, 600);
        chk("t4b_done_tick", 64'(done_tk), 64'd291);
        chk("t4b_error", 64'(error), 64'd0);
        dly_idx = -1; dly_val = 1;
        idle_ticks(2);

        // Stray start during write idx 3, then a restart with the new cfg
        run_seq(4, 400);
        chk("t5_done_tick", 64'(done_tk), 64'd37);
        chk("t5_writes", 64'(wr_cnt), 64'd9);
        idle_ticks(2);
        run_seq(-1, 400);
        chk("t5b_done_tick", 64'(done_tk), 64'd37);
        chk("t5b_wr0_data", wr_log_data[0], 64'h0000_FEFD_FCFB_FAF9);
        idle_ticks(2);

        // Reset while waiting for read idx 6, late readdatavalid ignored
        dly_idx = 6; dly_val = 4;
        begin_seq();
        while (tk < 29) tick();
        chk("t6_in_rd_wait", 64'({busy, avm_read, avm_write}), 64'b100);
        reset = 1'b1;
        seq_active = 1'b0;
        tick();
        reset = 1'b0;
        chk("t6_rst_read", 64'(avm_read), 64'd0);
        chk("t6_rst_write", 64'(avm_write), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        idle_ticks(6);
        chk("t6_error", 64'(error), 64'd0);
        dly_idx = -1; dly_val = 1;
        run_seq(-1, 400);
        chk("t6_fresh_done_tick", 64'(done_tk), 64'd37);
        chk("t6_fresh_error", 64'(error), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
